// File: rtl/associate_train.sv
// Training sequencer for one associate unit: streams a sample table through the forward
// port, returns thresholded errors for EPOCHS epochs, then runs one evaluation pass.
// Optional macro ASSOCIATE_TRAIN_EARLY_EN: end training after the first error-free epoch.
module associate_train #(
    parameter int ARGW   = 8,
    parameter int ARGD   = 2,
    parameter int RESW   = 16,
    parameter int ERRW   = 16,
    parameter int NUM    = 4,
    parameter int EPOCHS = 25,
    parameter logic [RESW-1:0] HIGH = 16'h00ff
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    smp_wr,
    input  logic [$clog2(NUM)-1:0]  smp_adr,
    input  logic [ARGD*ARGW-1:0]    smp_arg,
    input  logic [RESW-1:0]         smp_tgt,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [$clog2(NUM):0]    errs,
    output logic [7:0]              epochs,
    output logic                    en,
    output logic [ARGD*ARGW-1:0]    arg_dat,
    output logic                    arg_stb,
    input  logic                    arg_rdy,
    input  logic [RESW-1:0]         res_dat,
    input  logic                    res_stb,
    output logic                    res_rdy,
    output logic [ERRW-1:0]         err_dat,
    output logic                    err_stb,
    input  logic                    err_rdy,
    input  logic                    fbk_stb,
    output logic                    fbk_rdy
);
    localparam int AW = $clog2(NUM);

    typedef enum logic [2:0] {IDLE, ARG, RES, ERR, FBK, NEXT, DONE} state_t;
    state_t state, state_nx;

    logic [ARGD*ARGW-1:0] arg_tab [NUM];
    logic [RESW-1:0]      tgt_tab [NUM];
    logic [AW-1:0]        idx;
    logic [ERRW-1:0]      err_q;
    logic [RESW-1:0]      tgt;
    logic [RESW-1:0]      act;
    logic signed [RESW:0] e_wide;
    logic signed [ERRW-1:0] e;
    logic                 last;
    logic                 epoch_last;
    logic                 stop_train;

    always_ff @(posedge clk) begin
        if (smp_wr && !busy) begin
            arg_tab[smp_adr] <= smp_arg;
            tgt_tab[smp_adr] <= smp_tgt;
        end
    end

    // Error is formed one bit wider than the result so tgt - act cannot overflow before resizing.
    always_comb begin
        tgt        = tgt_tab[idx];
        act        = res_dat[RESW-1] ? '0 : HIGH;
        e_wide     = $signed({tgt[RESW-1], tgt}) - $signed({act[RESW-1], act});
        e          = ERRW'(e_wide);
        last       = (idx == AW'(NUM - 1));
        epoch_last = (epochs == 8'(EPOCHS - 1));
    end

`ifdef ASSOCIATE_TRAIN_EARLY_EN
    logic dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty <= 1'b0;
        end else if ((state == IDLE && start) || (state == NEXT && last)) begin
            dirty <= 1'b0;
        end else if (state == RES && res_stb && en && e != '0) begin
            dirty <= 1'b1;
        end
    end

    assign stop_train = epoch_last || !dirty;
`else
    assign stop_train = epoch_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        arg_stb  = 1'b0;
        res_rdy  = 1'b0;
        err_stb  = 1'b0;
        fbk_rdy  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = ARG;
            end
            ARG: begin
                arg_stb = 1'b1;
                if (arg_rdy) state_nx = RES;
            end
            RES: begin
                res_rdy = 1'b1;
                if (res_stb) state_nx = en ? ERR : NEXT;
            end
            ERR: begin
                err_stb = 1'b1;
                if (err_rdy) state_nx = FBK;
            end
            FBK: begin
                fbk_rdy = 1'b1;
                if (fbk_stb) state_nx = NEXT;
            end
            NEXT: state_nx = (last && !en) ? DONE : ARG;
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign arg_dat = arg_stb ? arg_tab[idx] : '0;
    assign err_dat = err_stb ? err_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            en     <= 1'b0;
            epochs <= '0;
            errs   <= '0;
            pass   <= 1'b0;
            err_q  <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    idx    <= '0;
                    en     <= 1'b1;
                    epochs <= '0;
                    errs   <= '0;
                    pass   <= 1'b0;
                end
                RES: if (res_stb) begin
                    if (en)            err_q <= e;
                    else if (e != '0)  errs  <= errs + 1'b1;
                end
                NEXT: begin
                    if (!last) begin
                        idx <= idx + 1'b1;
                    end else begin
                        idx <= '0;
                        if (en) begin
                            epochs <= epochs + 8'd1;
                            if (stop_train) en <= 1'b0;
                        end else begin
                            pass <= (errs == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_associate_train.sv
// Self-checking bench for associate_train: a stub associate answers the sequencer and a
// transaction-level model predicts every forward/backward transfer and the final report.
module tb_associate_train;
    localparam int ARGW   = 8;
    localparam int ARGD   = 2;
    localparam int RESW   = 16;
    localparam int ERRW   = 16;
    localparam int NUM    = 4;
    localparam int EPOCHS = 25;
    localparam int AW     = $clog2(NUM);
    localparam logic [15:0] HIGH = 16'h00ff;

    logic          clk = 1'b0;
    logic          rst, smp_wr, start;
    logic [AW-1:0] smp_adr;
    logic [15:0]   smp_arg, smp_tgt;
    logic          busy, done, pass, en;
    logic [AW:0]   errs;
    logic [7:0]    epochs;
    logic [15:0]   arg_dat, res_dat, err_dat;
    logic          arg_stb, arg_rdy, res_stb, res_rdy, err_stb, err_rdy, fbk_stb, fbk_rdy;

    associate_train #(
        .ARGW(ARGW), .ARGD(ARGD), .RESW(RESW), .ERRW(ERRW),
        .NUM(NUM), .EPOCHS(EPOCHS), .HIGH(HIGH)
    ) dut (
        .clk(clk), .rst(rst), .smp_wr(smp_wr), .smp_adr(smp_adr), .smp_arg(smp_arg),
        .smp_tgt(smp_tgt), .start(start), .busy(busy), .done(done), .pass(pass),
        .errs(errs), .epochs(epochs), .en(en), .arg_dat(arg_dat), .arg_stb(arg_stb),
        .arg_rdy(arg_rdy), .res_dat(res_dat), .res_stb(res_stb), .res_rdy(res_rdy),
        .err_dat(err_dat), .err_stb(err_stb), .err_rdy(err_rdy), .fbk_stb(fbk_stb),
        .fbk_rdy(fbk_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_arg [NUM];
    logic [15:0] m_tgt [NUM];
    int          m_idx, m_ep, m_errs;
    bit          m_train, m_dirty, m_fin;
    logic [15:0] exp_err [$];

    // One sample finished: step through the table, epochs, then the evaluation pass.
    function automatic void model_advance();
        m_idx++;
        if (m_idx == NUM) begin
            m_idx = 0;
            if (m_train) begin
                m_ep++;
`ifdef ASSOCIATE_TRAIN_EARLY_EN
                if (!m_dirty) m_train = 0;
`endif
                if (m_ep == EPOCHS) m_train = 0;
                m_dirty = 0;
            end else begin
                m_fin = 1;
            end
        end
    endfunction

    function automatic logic [15:0] model_error(logic [15:0] t, logic [15:0] r);
        int act;
        int diff;
        act  = (r[15] == 1'b1) ? 0 : int'(HIGH);
        diff = int'($signed(t)) - act;
        return diff[15:0];
    endfunction

    // Modes: 0 random result, 1 always correct, 2 stuck at ffff, 3 correct from learn_ep on.
    function automatic logic [15:0] pick_res(int mode, int learn_ep, logic [15:0] t);
        logic [15:0] r;
        r = 16'($urandom);
        if (mode == 2) return 16'hffff;
        if (mode == 1 || (mode == 3 && m_ep >= learn_ep)) r[15] = (t == HIGH) ? 1'b0 : 1'b1;
        return r;
    endfunction

    task automatic load_table();
        for (int i = 0; i < NUM; i++) begin
            @(negedge clk);
            smp_wr  = 1'b1;
            smp_adr = AW'(i);
            smp_arg = m_arg[i];
            smp_tgt = m_tgt[i];
        end
        @(negedge clk);
        smp_wr = 1'b0;
    endtask

    task automatic run(input string name, input int mode, input int learn_ep, input int exp_errs,
                       input int exp_pass, input bit stall, input bit inject, input int abort_ep,
                       output bit aborted);
        int cyc, nfwd, nbwd, arg_stall, err_stall, res_wait, fbk_wait;
        bit res_pend, fbk_pend, arg_hold, err_hold, got_done;
        logic [15:0] res_val, arg_prev, err_prev, want;
        m_idx = 0; m_ep = 0; m_errs = 0; m_train = 1; m_dirty = 0; m_fin = 0;
        exp_err.delete();
        cyc = 0; nfwd = 0; nbwd = 0; arg_stall = 0; err_stall = 0; res_wait = 0; fbk_wait = 0;
        res_pend = 0; fbk_pend = 0; arg_hold = 0; err_hold = 0; got_done = 0; aborted = 0;
        res_val = '0; arg_prev = '0; err_prev = '0;
        @(negedge clk);
        start = 1'b1;
        while (!got_done && !aborted && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start  = 1'b0;
            smp_wr = 1'b0;
            if (done === 1'b1) begin
                got_done = 1;
                checks++;
                if (!m_fin) begin
                    failures++;
                    $display("FAIL %s done_early: done=1 after %0d forward transfers, required evaluation complete", name, nfwd);
                end
                checks++;
                if (pass !== (m_errs == 0)) begin
                    failures++;
                    $display("FAIL %s pass: got %b required %b", name, pass, (m_errs == 0));
                end
                checks++;
                if (errs !== (AW+1)'(m_errs)) begin
                    failures++;
                    $display("FAIL %s errs: got %0d required %0d", name, errs, m_errs);
                end
                checks++;
                if (epochs !== 8'(m_ep)) begin
                    failures++;
                    $display("FAIL %s epochs: got %0d required %0d", name, epochs, m_ep);
                end
                checks++;
                if (nfwd != NUM * m_ep + NUM || nbwd != NUM * m_ep) begin
                    failures++;
                    $display("FAIL %s transfers: fwd=%0d bwd=%0d required fwd=%0d bwd=%0d", name, nfwd, nbwd, NUM * m_ep + NUM, NUM * m_ep);
                end
                checks++;
                if (busy !== 1'b0 || en !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_state: busy=%b en=%b required 0 0", name, busy, en);
                end
                if (exp_errs >= 0) begin
                    checks++;
                    if (errs !== (AW+1)'(exp_errs)) begin
                        failures++;
                        $display("FAIL %s errs_fixed: got %0d required %0d", name, errs, exp_errs);
                    end
                end
                if (exp_pass >= 0) begin
                    checks++;
                    if (pass !== exp_pass[0]) begin
                        failures++;
                        $display("FAIL %s pass_fixed: got %b required %0d", name, pass, exp_pass);
                    end
                end
`ifndef ASSOCIATE_TRAIN_EARLY_EN
                checks++;
                if (epochs !== 8'(EPOCHS)) begin
                    failures++;
                    $display("FAIL %s epochs_full: got %0d required %0d", name, epochs, EPOCHS);
                end
`endif
            end else begin
                if (arg_hold) begin
                    checks++;
                    if (arg_stb !== 1'b1 || arg_dat !== arg_prev) begin
                        failures++;
                        $display("FAIL %s arg_hold: stb=%b dat=%h required stb=1 dat=%h", name, arg_stb, arg_dat, arg_prev);
                    end
                end
                if (err_hold) begin
                    checks++;
                    if (err_stb !== 1'b1 || err_dat !== err_prev) begin
                        failures++;
                        $display("FAIL %s err_hold: stb=%b dat=%h required stb=1 dat=%h", name, err_stb, err_dat, err_prev);
                    end
                end
                res_stb = 1'b0;
                if (res_pend) begin
                    if (res_wait > 0) begin
                        res_wait--;
                    end else begin
                        res_stb = 1'b1;
                        res_dat = res_val;
                        if (res_rdy === 1'b1) begin
                            want = model_error(m_tgt[m_idx], res_val);
                            if (m_train) begin
                                exp_err.push_back(want);
                                if (want != 0) m_dirty = 1;
                            end else begin
                                if (want != 0) m_errs++;
                                model_advance();
                            end
                            res_pend = 0;
                        end
                    end
                end
                fbk_stb = 1'b0;
                if (fbk_pend) begin
                    if (fbk_wait > 0) begin
                        fbk_wait--;
                    end else begin
                        fbk_stb = 1'b1;
                        if (fbk_rdy === 1'b1) begin
                            fbk_pend = 0;
                            model_advance();
                        end
                    end
                end
                if (arg_stb && !arg_hold) arg_stall = (stall && nfwd == 8) ? 5 : int'($urandom_range(0, 2));
                arg_rdy = (arg_stall == 0);
                if (arg_stall > 0) arg_stall--;
                if (arg_stb === 1'b1 && arg_rdy) begin
                    checks++;
                    if (m_fin || arg_dat !== m_arg[m_idx]) begin
                        failures++;
                        $display("FAIL %s arg_dat: got %h required %h (sample %0d, finished=%0b)", name, arg_dat, m_arg[m_idx], m_idx, m_fin);
                    end
                    checks++;
                    if (en !== m_train) begin
                        failures++;
                        $display("FAIL %s en_fwd: got %b required %b (epoch %0d)", name, en, m_train, m_ep);
                    end
                    nfwd++;
                    res_pend = 1;
                    res_wait = int'($urandom_range(0, 2));
                    res_val  = pick_res(mode, learn_ep, m_tgt[m_idx]);
                end
                arg_hold = arg_stb && !arg_rdy;
                arg_prev = arg_dat;
                if (abort_ep >= 0 && err_stb === 1'b1 && m_ep == abort_ep) begin
                    rst = 1'b1;
                    aborted = 1;
                    res_stb = 1'b0;
                    fbk_stb = 1'b0;
                end else begin
                    if (err_stb && !err_hold) err_stall = (stall && nbwd == 9) ? 3 : int'($urandom_range(0, 1));
                    err_rdy = (err_stall == 0);
                    if (err_stall > 0) err_stall--;
                    if (err_stb === 1'b1 && err_rdy) begin
                        checks++;
                        if (exp_err.size() == 0) begin
                            failures++;
                            $display("FAIL %s err_extra: backward transfer dat=%h, required none", name, err_dat);
                        end else begin
                            want = exp_err.pop_front();
                            if (err_dat !== want) begin
                                failures++;
                                $display("FAIL %s err_dat: got %h required %h", name, err_dat, want);
                            end
                        end
                        checks++;
                        if (en !== 1'b1) begin
                            failures++;
                            $display("FAIL %s en_bwd: got %b required 1", name, en);
                        end
                        nbwd++;
                        fbk_pend = 1;
                        fbk_wait = int'($urandom_range(0, 2));
                    end
                    err_hold = err_stb && !err_rdy;
                    err_prev = err_dat;
                end
                if (inject && cyc == 30 && busy === 1'b1) begin
                    start   = 1'b1;
                    smp_wr  = 1'b1;
                    smp_adr = AW'(2);
                    smp_arg = 16'($urandom);
                    smp_tgt = 16'($urandom);
                end
            end
        end
        res_stb = 1'b0;
        fbk_stb = 1'b0;
        arg_rdy = 1'b1;
        err_rdy = 1'b1;
        if (!got_done && !aborted) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles, required done", name, cyc);
        end
        if (got_done) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || pass !== (m_errs == 0)) begin
                failures++;
                $display("FAIL %s after_done: done=%b pass=%b required done=0 pass=%b", name, done, pass, (m_errs == 0));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pass, en, arg_stb, res_rdy, err_stb, fbk_rdy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctl: busy,done,pass,en,arg_stb,res_rdy,err_stb,fbk_rdy=%b required 00000000",
                     {busy, done, pass, en, arg_stb, res_rdy, err_stb, fbk_rdy});
        end
        checks++;
        if (errs !== '0 || epochs !== '0 || arg_dat !== '0 || err_dat !== '0) begin
            failures++;
            $display("FAIL reset_data: errs=%0d epochs=%0d arg=%h err=%h required all 0", errs, epochs, arg_dat, err_dat);
        end
        rst = 1'b0;
    endtask

    task automatic set_logic_table(input bit is_or);
        for (int i = 0; i < NUM; i++) begin
            m_arg[i] = {(i[1] ? 8'hff : 8'h00), (i[0] ? 8'hff : 8'h00)};
            if (is_or) m_tgt[i] = (i != 0) ? HIGH : 16'h0000;
            else       m_tgt[i] = (i == NUM - 1) ? HIGH : 16'h0000;
        end
        load_table();
    endtask

    task automatic test_and();
        bit ab;
        set_logic_table(1'b0);
        run("and", 3, int'($urandom_range(0, 10)), 0, 1, 0, 0, -1, ab);
    endtask

    task automatic test_or();
        bit ab;
        test_reset();
        set_logic_table(1'b1);
        run("or", 3, int'($urandom_range(0, 10)), 0, 1, 0, 0, -1, ab);
    endtask

    task automatic test_stuck();
        bit ab;
        for (int i = 0; i < NUM; i++) begin
            m_arg[i] = 16'($urandom);
            m_tgt[i] = 16'h00ff;
        end
        load_table();
        run("stuck", 2, 0, 4, 0, 0, 0, -1, ab);
    endtask

    task automatic test_back_to_back_stall();
        bit ab;
        for (int i = 0; i < NUM; i++) begin
            m_arg[i] = 16'($urandom);
            m_tgt[i] = 16'($urandom);
        end
        load_table();
        run("stall", 0, 0, -1, -1, 1, 0, -1, ab);
        run("back_to_back", 0, 0, -1, -1, 0, 0, -1, ab);
    endtask

    task automatic test_busy_ignore();
        bit ab;
        set_logic_table(1'b0);
        run("busy_ignore", 1, 0, 0, 1, 0, 1, -1, ab);
        run("busy_table", 1, 0, 0, 1, 0, 0, -1, ab);
    endtask

    task automatic test_reset_midrun();
        bit ab;
        int seen;
        run("midrun", 0, 0, -1, -1, 0, 0, 2, ab);
        checks++;
        if (!ab) begin
            failures++;
            $display("FAIL midrun_abort: reached=%0b required ERR in epoch 2", ab);
        end
        @(negedge clk);
        checks++;
        if ({arg_stb, err_stb, res_rdy, fbk_rdy, busy, done, pass, en} !== 8'h00) begin
            failures++;
            $display("FAIL midrun_reset: arg_stb,err_stb,res_rdy,fbk_rdy,busy,done,pass,en=%b required 00000000",
                     {arg_stb, err_stb, res_rdy, fbk_rdy, busy, done, pass, en});
        end
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrun_done: done pulsed %0d times, required 0", seen);
        end
        run("after_reset", 1, 0, 0, 1, 0, 0, -1, ab);
    endtask

    task automatic test_random();
        bit ab;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM; i++) begin
                m_arg[i] = 16'($urandom);
                m_tgt[i] = (($urandom & 1) != 0) ? 16'($urandom) : (($urandom & 1) != 0 ? HIGH : 16'h0000);
            end
            load_table();
            run("random", 0, 0, -1, -1, 0, 0, -1, ab);
        end
    endtask

    initial begin
        rst = 1'b0; smp_wr = 1'b0; start = 1'b0; smp_adr = '0; smp_arg = '0; smp_tgt = '0;
        arg_rdy = 1'b1; res_dat = '0; res_stb = 1'b0; err_rdy = 1'b1; fbk_stb = 1'b0;
        test_reset();
        test_and();
        test_or();
        test_stuck();
        test_back_to_back_stall();
        test_busy_ignore();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/associate_train.md
Name: associate_train

Overview:
- Training sequencer for one `associate` unit.
- Holds a small sample/target table and streams each sample through the unit's forward port.
- Thresholds each result, computes the error and returns it on the backward port, repeating for a fixed number of epochs.
- Finishes with one evaluation pass with learning disabled and reports pass/fail. Replaces hand-sequenced training loops in benches and firmware.

Parameters:
- ARGW, 8, width of one argument element
- ARGD, 2, argument elements per sample
- RESW, 16, result width (signed)
- ERRW, 16, error width (signed)
- NUM, 4, samples in the table (power of two, ≥2)
- EPOCHS, 25, training epochs per run (1..255)
- HIGH, 16'h00ff, activation level for a non-negative result

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- smp_wr  in  1  sample table write strobe
- smp_adr  in  $clog2(NUM)  sample table index
- smp_arg  in  ARGD*ARGW  sample argument
- smp_tgt  in  RESW  sample target (signed)
- start  in  1  begin a run (one-cycle pulse)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  evaluation result, valid from done until next start
- errs  out  $clog2(NUM)+1  mismatching samples in evaluation pass
- epochs  out  8  training epochs completed in last run
- en  out  1  learning enable to associate
- arg_dat  out  ARGD*ARGW  forward argument
- arg_stb  out  1  forward argument valid
- arg_rdy  in  1  forward argument ready
- res_dat  in  RESW  forward result
- res_stb  in  1  result valid
- res_rdy  out  1  result ready
- err_dat  out  ERRW  backward error
- err_stb  out  1  error valid
- err_rdy  in  1  error ready
- fbk_stb  in  1  feedback valid (data discarded)
- fbk_rdy  out  1  feedback ready

Behaviour:
- Reset: all outputs 0; state IDLE; table contents unchanged.
- Handshake rule: a transfer occurs on a rising edge with stb&&rdy. Once raised, stb and its data hold stable until accepted.
- res_rdy is 1 only in RES. fbk_rdy is 1 only in FBK.
- Table writes take effect when smp_wr=1 and busy=0. Writes while busy are ignored.
- start while busy is ignored.
- FSM states:
  - IDLE: on start, go to ARG with sample index 0, epoch counter 0, en=1, busy=1, errs/epochs/pass cleared.
  - ARG: arg_stb=1, arg_dat=table[idx]; go to RES on accept.
  - RES: on res_stb, act = ($signed(res_dat)<0) ? 0 : HIGH; e = tgt - act, computed in RESW+1 bits, then sign-extended or truncated to ERRW.
    - Training (en=1): register e, go to ERR.
    - Evaluation (en=0): if e≠0, increment errs; go to NEXT.
  - ERR: err_stb=1, err_dat=e; go to FBK on accept. Backward is issued even when e=0.
  - FBK: wait for fbk_stb, then go to NEXT.
  - NEXT: if idx<NUM-1, increment idx and go to ARG. Otherwise idx=0 and:
    - Training: increment epochs. If epochs==EPOCHS, set en=0 (evaluation). Go to ARG.
    - Evaluation: go to DONE.
  - DONE: done=1 for one cycle; pass=(errs==0); busy=0; en=0; go to IDLE.
- Minimum latency per training sample is 4 handshake cycles plus 1 NEXT cycle.
- en changes only in NEXT/IDLE transitions, never while a forward or backward transfer is pending.
- Reset mid-run: on the next edge, all strobes drop, state goes to IDLE, done is not pulsed, and pass=0.

Optional Feature:
- Macro ASSOCIATE_TRAIN_EARLY_EN.
- When defined: a per-epoch flag records any nonzero e. At the end of a training epoch with no nonzero e, evaluation starts immediately, and epochs reports the epochs actually run.
- When undefined: exactly EPOCHS training epochs always run. The flag logic is absent.

Test Plan:
- AND table {0000→0000, 00ff→0000, ff00→0000, ffff→00ff} with a real associate (RATE=1), start → done pulses, pass=1, errs=0, epochs=25 (≤25 with ASSOCIATE_TRAIN_EARLY_EN).
- OR table {0000→0000, 00ff→00ff, ff00→00ff, ffff→00ff} after reset, start → pass=1, errs=0.
- Stub associate always returning res=16'hffff, all targets 00ff → every err_dat=16'h00ff, epochs=25, errs=4, pass=0, en=0 during the last 4 forward transfers.
- Stub holds arg_rdy=0 for 5 cycles, then err_rdy=0 for 3 cycles → arg_stb/arg_dat and err_stb/err_dat stay stable, with no duplicate or lost transfers (count exactly 4*EPOCHS+4 forward and 4*EPOCHS backward).
- start pulse and smp_wr to idx 2 while busy → run unaffected, table[2] unchanged after done.
- rst asserted in epoch 3 during ERR → next cycle all strobes 0, busy=0, done never pulses; a new start then completes normally.
